// File: rtl/wb_port_arbiter_pkg.sv
// rv_wb_pkg: types and constants shared by the writeback-port arbiter and its
// MDU result FIFO.
//   REG_ADDR_W / XLEN   register address and data widths
//   wb_entry_t          one buffered MDU result (destination + data)
//   IDLE/PENDING/FORCE  starvation FSM state encoding
//   regOneHot()         one-hot decode of a register address
package rv_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       wd;
    } wb_entry_t;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] FORCE   = 2'd2;

    function automatic logic [XLEN-1:0] regOneHot(input logic [REG_ADDR_W-1:0] r);
        return XLEN'(1) << r;
    endfunction

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// wb_result_fifo: circular buffer holding MDU results waiting for an idle
// register-file write slot. The head entry is visible combinationally so the
// arbiter can write it in the same cycle it is granted.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   push, pushData  enqueue request and entry (ignored when full)
//   pop             dequeue the head (ignored when empty)
//   headData        current head entry
//   full, empty     occupancy flags
//   count           number of valid entries (0..DEPTH)
module wb_result_fifo
    import rv_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  pushData,
    input  logic                       pop,
    output wb_entry_t                  headData,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wrPtrReg;
    logic [AW-1:0]     rdPtrReg;
    logic [CW-1:0]     countReg;
    logic              doPush;
    logic              doPop;

    assign full     = (countReg == CW'(DEPTH));
    assign empty    = (countReg == '0);
    assign count    = countReg;
    assign doPush   = push && !full;
    assign doPop    = pop && !empty;
    assign headData = mem[rdPtrReg];

    // Storage has no reset: stale contents are never visible because the
    // head is only consumed while count is non-zero.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg] <= pushData;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the wrap.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + AW'(1);
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   countReg <= countReg + CW'(1);
                2'b01:   countReg <= countReg - CW'(1);
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the register-file write port between the pipeline
// writeback stage (always first) and buffered MDU results, which drain into
// idle slots. A starvation FSM requests a writeback bubble when the buffered
// head has waited too long, and a busy scoreboard marks destinations with an
// outstanding MDU write.
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   pipe_we/pipe_rd/pipe_wd           writeback-stage write request
//   mdu_issue/mdu_issue_rd            MDU issue, marks destination busy
//   mdu_valid/mdu_rd/mdu_wd/mdu_ready MDU result handshake
//   rf_we/rf_rd/rf_wd                 register-file write port
//   busy_mask                         outstanding MDU destinations (bit 0 = 0)
//   stall_req                         registered request to bubble writeback
module wb_port_arbiter
    import rv_wb_pkg::*;
#(
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [REG_ADDR_W-1:0] pipe_rd,
    input  logic [XLEN-1:0]       pipe_wd,
    input  logic                  mdu_issue,
    input  logic [REG_ADDR_W-1:0] mdu_issue_rd,
    input  logic                  mdu_valid,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_wd,
    output logic                  mdu_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_rd,
    output logic [XLEN-1:0]       rf_wd,
    output logic [XLEN-1:0]       busy_mask,
    output logic                  stall_req
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    wb_entry_t       headEntry;
    wb_entry_t       pushEntry;
    logic            fifoFull;
    logic            fifoEmpty;
    logic [CW-1:0]   fifoCount;

    logic            pipeWrite;
    logic            grant;
    logic            acceptWrite;
    logic            fifoDrains;

    logic [1:0]      stateReg;
    logic [1:0]      stateNext;
    logic [SW-1:0]   starveReg;
    logic [SW-1:0]   starveNext;
    logic            stallReg;
    logic [XLEN-1:1] busyReg;

    // A write to x0 is architecturally a no-op, so it leaves the slot free.
    assign pipeWrite = pipe_we && (pipe_rd != '0);
    assign grant     = !pipeWrite && !fifoEmpty;

    // Ready depends only on the registered occupancy, never on a same-cycle pop.
    assign mdu_ready   = !fifoFull;
    assign acceptWrite = mdu_valid && mdu_ready && (mdu_rd != '0);

    assign pushEntry.rd = mdu_rd;
    assign pushEntry.wd = mdu_wd;

    wb_result_fifo #(
        .DEPTH    (FIFO_DEPTH)
    ) resultFifo (
        .clk      (clk),
        .rst      (rst),
        .push     (acceptWrite),
        .pushData (pushEntry),
        .pop      (grant),
        .headData (headEntry),
        .full     (fifoFull),
        .empty    (fifoEmpty),
        .count    (fifoCount)
    );

    assign rf_we = pipeWrite || grant;
    assign rf_rd = pipeWrite ? pipe_rd : headEntry.rd;
    assign rf_wd = pipeWrite ? pipe_wd : headEntry.wd;

    // The last entry leaves this cycle and nothing replaces it.
    assign fifoDrains = grant && (fifoCount == CW'(1)) && !acceptWrite;

    always_comb begin
        stateNext  = stateReg;
        starveNext = starveReg;
        case (stateReg)
            IDLE: begin
                starveNext = '0;
                if (acceptWrite) begin
                    stateNext = PENDING;
                end
            end
            PENDING: begin
                if (grant) begin
                    starveNext = '0;
                    if (fifoDrains) begin
                        stateNext = IDLE;
                    end
                end else begin
                    starveNext = starveReg + SW'(1);
                    if (starveReg + SW'(1) == SW'(STARVE_LIMIT)) begin
                        stateNext = FORCE;
                    end
                end
            end
            FORCE: begin
                // Counter holds at the limit until the head finally gets a slot.
                if (grant) begin
                    starveNext = '0;
                    stateNext  = fifoDrains ? IDLE : PENDING;
                end
            end
            default: begin
                stateNext  = IDLE;
                starveNext = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg  <= IDLE;
            starveReg <= '0;
            stallReg  <= 1'b0;
        end else begin
            stateReg  <= stateNext;
            starveReg <= starveNext;
            stallReg  <= (stateNext == FORCE);
        end
    end

    assign stall_req = stallReg;

    // Scoreboard: one flop per architectural register except x0. An issue to
    // a register outranks the retirement of an older write to the same one.
    for (genvar gi = 1; gi < XLEN; gi++) begin : gBusy
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                busyReg[gi] <= 1'b0;
            end else if (mdu_issue && (mdu_issue_rd == REG_ADDR_W'(gi))) begin
                busyReg[gi] <= 1'b1;
            end else if (grant && (headEntry.rd == REG_ADDR_W'(gi))) begin
                busyReg[gi] <= 1'b0;
            end
        end
    end

    assign busy_mask = {busyReg, 1'b0};

endmodule
